// File: rtl/lan_egress_formatter.sv
// lan_egress_formatter
// Egress formatter between the to_nb switch and the LAN router. Each packet's
// route is decided once, on its first beat: dest IP 0 is dropped and counted,
// dest IP equal to the local IP is looped back toward the from_nb switch with a
// local-source TUSER, and everything else goes to the router with
// TUSER = {dest port, dest IP}. A single output register stage gives one cycle
// of latency and full throughput.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for the first beat of a packet; route decided here
// FWD_ROUTER | forwarding remaining beats to the LAN router
// FWD_LOOP   | forwarding remaining beats to the loopback (from_nb) port
// DROP       | discarding remaining beats of a dest-IP-0 packet
module lan_egress_formatter #(
    parameter int AXIS_DATA_WIDTH          = 64,
    parameter int AXIS_KEEP_WIDTH          = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_TDEST_WIDTH         = 8,
    parameter int IP_ADDRESS_WIDTH         = 32,
    parameter int IP_PORT_WIDTH            = 16,
    parameter int AXIS_TO_NB_TUSER_WIDTH   = 64,
    parameter int AXIS_LAN_TUSER_WIDTH     = 48,
    parameter int AXIS_FROM_NB_TUSER_WIDTH = 64
) (
    input  logic                                i_clk,
    input  logic                                i_ap_rst,
    input  logic [IP_ADDRESS_WIDTH-1:0]         i_local_ip_address,
    input  logic [IP_PORT_WIDTH-1:0]            i_LAN_port_number,

    input  logic                                from_switch_tvalid,
    output logic                                from_switch_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]          from_switch_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]          from_switch_tkeep,
    input  logic [AXIS_TDEST_WIDTH-1:0]         from_switch_tid,
    input  logic [AXIS_TDEST_WIDTH-1:0]         from_switch_tdest,
    input  logic [AXIS_TO_NB_TUSER_WIDTH-1:0]   from_switch_tuser,
    input  logic                                from_switch_tlast,

    output logic                                to_router_tvalid,
    input  logic                                to_router_tready,
    output logic [AXIS_DATA_WIDTH-1:0]          to_router_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]          to_router_tkeep,
    output logic [AXIS_TDEST_WIDTH-1:0]         to_router_tid,
    output logic [AXIS_TDEST_WIDTH-1:0]         to_router_tdest,
    output logic [AXIS_LAN_TUSER_WIDTH-1:0]     to_router_tuser,
    output logic                                to_router_tlast,

    output logic                                to_loopback_tvalid,
    input  logic                                to_loopback_tready,
    output logic [AXIS_DATA_WIDTH-1:0]          to_loopback_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]          to_loopback_tkeep,
    output logic [AXIS_TDEST_WIDTH-1:0]         to_loopback_tid,
    output logic [AXIS_TDEST_WIDTH-1:0]         to_loopback_tdest,
    output logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] to_loopback_tuser,
    output logic                                to_loopback_tlast,

    output logic [15:0]                         o_drop_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FWD_ROUTER = 2'd1,
        FWD_LOOP   = 2'd2,
        DROP       = 2'd3
    } state_t;

    state_t                              state;

    // Output register stage; out_sel = 1 selects the loopback port.
    logic                                out_vld;
    logic                                out_sel;
    logic [AXIS_DATA_WIDTH-1:0]          out_data;
    logic [AXIS_KEEP_WIDTH-1:0]          out_keep;
    logic [AXIS_TDEST_WIDTH-1:0]         out_id;
    logic [AXIS_TDEST_WIDTH-1:0]         out_dest;
    logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] out_user;
    logic                                out_last;

    // Per-packet values captured on the first beat.
    logic [IP_ADDRESS_WIDTH-1:0]         lat_dest_ip;
    logic [IP_PORT_WIDTH-1:0]            lat_dest_port;
    logic [IP_ADDRESS_WIDTH-1:0]         lat_local_ip;
    logic [IP_PORT_WIDTH-1:0]            lat_lan_port;

    logic [IP_ADDRESS_WIDTH-1:0]         in_dest_ip;
    logic [IP_PORT_WIDTH-1:0]            in_dest_port;
    logic                                in_is_drop;
    logic                                in_is_loop;
    logic                                sel_tready;
    logic                                out_fire;
    logic                                accept;
    logic                                load_en;
    logic                                load_sel;
    logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] load_user;

    // The source port carried on input TUSER has no use on either egress path.
    logic                                unused_src_port;

    assign unused_src_port = ^from_switch_tuser[63:48];

    assign in_dest_ip   = from_switch_tuser[31:0];
    assign in_dest_port = from_switch_tuser[47:32];
    assign in_is_drop   = (in_dest_ip == '0);
    assign in_is_loop   = (in_dest_ip == i_local_ip_address);

    assign sel_tready = out_sel ? to_loopback_tready : to_router_tready;
    assign out_fire   = out_vld && sel_tready;

    // DROP discards unconditionally, so it never waits on the output stage.
    assign from_switch_tready = (state == DROP) || !out_vld || sel_tready;
    assign accept             = from_switch_tvalid && from_switch_tready;

    // Decide whether the accepted beat loads the output stage and with which TUSER.
    always_comb begin
        load_en   = 1'b0;
        load_sel  = 1'b0;
        load_user = '0;
        case (state)
            IDLE: begin
                if (accept && !in_is_drop) begin
                    load_en   = 1'b1;
                    load_sel  = in_is_loop;
                    load_user = in_is_loop
                              ? {in_dest_port, i_LAN_port_number, i_local_ip_address}
                              : {16'h0000, in_dest_port, in_dest_ip};
                end
            end
            FWD_ROUTER: begin
                if (accept) begin
                    load_en   = 1'b1;
                    load_user = {16'h0000, lat_dest_port, lat_dest_ip};
                end
            end
            FWD_LOOP: begin
                if (accept) begin
                    load_en   = 1'b1;
                    load_sel  = 1'b1;
                    load_user = {lat_dest_port, lat_lan_port, lat_local_ip};
                end
            end
            default: begin
                load_en = 1'b0;
            end
        endcase
    end

    // Routing FSM, output register stage, per-packet latches and drop counter.
    always_ff @(posedge i_clk) begin
        if (i_ap_rst) begin
            state         <= IDLE;
            out_vld       <= 1'b0;
            out_sel       <= 1'b0;
            out_data      <= '0;
            out_keep      <= '0;
            out_id        <= '0;
            out_dest      <= '0;
            out_user      <= '0;
            out_last      <= 1'b0;
            lat_dest_ip   <= '0;
            lat_dest_port <= '0;
            lat_local_ip  <= '0;
            lat_lan_port  <= '0;
            o_drop_count  <= '0;
        end else begin
            if (load_en) begin
                out_vld  <= 1'b1;
                out_sel  <= load_sel;
                out_data <= from_switch_tdata;
                out_keep <= from_switch_tkeep;
                out_id   <= from_switch_tid;
                out_dest <= from_switch_tdest;
                out_user <= load_user;
                out_last <= from_switch_tlast;
            end else if (out_fire) begin
                out_vld <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_dest_ip   <= in_dest_ip;
                        lat_dest_port <= in_dest_port;
                        lat_local_ip  <= i_local_ip_address;
                        lat_lan_port  <= i_LAN_port_number;
                        if (in_is_drop) begin
                            if (o_drop_count != 16'hFFFF) begin
                                o_drop_count <= o_drop_count + 16'd1;
                            end
                            if (!from_switch_tlast) begin
                                state <= DROP;
                            end
                        end else if (!from_switch_tlast) begin
                            state <= in_is_loop ? FWD_LOOP : FWD_ROUTER;
                        end
                    end
                end
                default: begin
                    if (accept && from_switch_tlast) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign to_router_tvalid = out_vld && !out_sel;
    assign to_router_tdata  = out_data;
    assign to_router_tkeep  = out_keep;
    assign to_router_tid    = out_id;
    assign to_router_tdest  = out_dest;
    assign to_router_tuser  = out_user[AXIS_LAN_TUSER_WIDTH-1:0];
    assign to_router_tlast  = out_last;

    assign to_loopback_tvalid = out_vld && out_sel;
    assign to_loopback_tdata  = out_data;
    assign to_loopback_tkeep  = out_keep;
    assign to_loopback_tid    = out_id;
    assign to_loopback_tdest  = out_dest;
    assign to_loopback_tuser  = out_user;
    assign to_loopback_tlast  = out_last;

endmodule

// File: tb/tb_lan_egress_formatter.sv
// Testbench for lan_egress_formatter: directed scenarios plus a randomized
// run, checked by a scoreboard of expected beats per egress port.
module tb_lan_egress_formatter;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [7:0]  id;
        logic [7:0]  dest;
        logic [63:0] user;
        logic        last;
    } beat_t;

    localparam logic [31:0] IP_A = 32'h0A000001;
    localparam logic [31:0] IP_B = 32'h0A000003;

    logic        clk = 1'b0;
    logic        i_ap_rst;
    logic [31:0] i_local_ip_address;
    logic [15:0] i_LAN_port_number;

    logic        from_switch_tvalid;
    logic        from_switch_tready;
    logic [63:0] from_switch_tdata;
    logic [7:0]  from_switch_tkeep;
    logic [7:0]  from_switch_tid;
    logic [7:0]  from_switch_tdest;
    logic [63:0] from_switch_tuser;
    logic        from_switch_tlast;

    logic        to_router_tvalid;
    logic        to_router_tready;
    logic [63:0] to_router_tdata;
    logic [7:0]  to_router_tkeep;
    logic [7:0]  to_router_tid;
    logic [7:0]  to_router_tdest;
    logic [47:0] to_router_tuser;
    logic        to_router_tlast;

    logic        to_loopback_tvalid;
    logic        to_loopback_tready;
    logic [63:0] to_loopback_tdata;
    logic [7:0]  to_loopback_tkeep;
    logic [7:0]  to_loopback_tid;
    logic [7:0]  to_loopback_tdest;
    logic [63:0] to_loopback_tuser;
    logic        to_loopback_tlast;

    logic [15:0] o_drop_count;

    int    n_checks = 0;
    int    n_errors = 0;
    bit    rand_ready = 1'b0;
    logic [15:0] drop_exp = 16'd0;
    beat_t q_rtr[$];
    beat_t q_lp[$];

    lan_egress_formatter dut (
        .i_clk              (clk),
        .i_ap_rst           (i_ap_rst),
        .i_local_ip_address (i_local_ip_address),
        .i_LAN_port_number  (i_LAN_port_number),
        .from_switch_tvalid (from_switch_tvalid),
        .from_switch_tready (from_switch_tready),
        .from_switch_tdata  (from_switch_tdata),
        .from_switch_tkeep  (from_switch_tkeep),
        .from_switch_tid    (from_switch_tid),
        .from_switch_tdest  (from_switch_tdest),
        .from_switch_tuser  (from_switch_tuser),
        .from_switch_tlast  (from_switch_tlast),
        .to_router_tvalid   (to_router_tvalid),
        .to_router_tready   (to_router_tready),
        .to_router_tdata    (to_router_tdata),
        .to_router_tkeep    (to_router_tkeep),
        .to_router_tid      (to_router_tid),
        .to_router_tdest    (to_router_tdest),
        .to_router_tuser    (to_router_tuser),
        .to_router_tlast    (to_router_tlast),
        .to_loopback_tvalid (to_loopback_tvalid),
        .to_loopback_tready (to_loopback_tready),
        .to_loopback_tdata  (to_loopback_tdata),
        .to_loopback_tkeep  (to_loopback_tkeep),
        .to_loopback_tid    (to_loopback_tid),
        .to_loopback_tdest  (to_loopback_tdest),
        .to_loopback_tuser  (to_loopback_tuser),
        .to_loopback_tlast  (to_loopback_tlast),
        .o_drop_count       (o_drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Random backpressure on both egress ports when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) begin
                to_router_tready   = ($urandom_range(0, 9) < 6);
                to_loopback_tready = ($urandom_range(0, 9) < 6);
            end
        end
    end

    // Monitor: every output handshake pops and compares the head of that port's queue.
    initial begin
        beat_t act;
        beat_t exp;
        forever begin
            @(negedge clk);
            if (!i_ap_rst) begin
                n_checks++;
                if (to_router_tvalid && to_loopback_tvalid) begin
                    n_errors++;
                    $display("FAIL both_valid: router and loopback tvalid both 1");
                end
                if (to_router_tvalid && to_router_tready) begin
                    act = '{to_router_tdata, to_router_tkeep, to_router_tid, to_router_tdest,
                            {16'h0000, to_router_tuser}, to_router_tlast};
                    n_checks++;
                    if (q_rtr.size() == 0) begin
                        n_errors++;
                        $display("FAIL router_unexpected: got %h expected no beat", act);
                    end else begin
                        exp = q_rtr.pop_front();
                        if (act !== exp) begin
                            n_errors++;
                            $display("FAIL router_beat: got %h expected %h", act, exp);
                        end
                    end
                end
                if (to_loopback_tvalid && to_loopback_tready) begin
                    act = '{to_loopback_tdata, to_loopback_tkeep, to_loopback_tid, to_loopback_tdest,
                            to_loopback_tuser, to_loopback_tlast};
                    n_checks++;
                    if (q_lp.size() == 0) begin
                        n_errors++;
                        $display("FAIL loop_unexpected: got %h expected no beat", act);
                    end else begin
                        exp = q_lp.pop_front();
                        if (act !== exp) begin
                            n_errors++;
                            $display("FAIL loop_beat: got %h expected %h", act, exp);
                        end
                    end
                end
            end
        end
    end

    // Present one beat (already on the bus) and wait for it to be accepted.
    task automatic send_beat(output int stalls);
        stalls = 0;
        from_switch_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (from_switch_tready) break;
            stalls++;
            if (stalls > 300) begin
                n_checks++;
                n_errors++;
                $display("FAIL accept_timeout: tready stayed %0b", from_switch_tready);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Reference model: route chosen from the first beat by the forwarding rules,
    // expected egress beats pushed to the matching queue before driving.
    task automatic send_packet(input logic [31:0] ip, input logic [15:0] port, input int n,
                               input bit gaps, input bit chk_lat, input bit mid_ip,
                               output int stalls);
        int    route;
        int    w;
        logic [31:0] loc;
        logic [15:0] lan;
        beat_t b;
        beat_t e;
        stalls = 0;
        loc = i_local_ip_address;
        lan = i_LAN_port_number;
        if (ip == 32'd0) route = 0;
        else if (ip == loc) route = 2;
        else route = 1;
        if (route == 0 && drop_exp != 16'hFFFF) drop_exp = drop_exp + 16'd1;
        for (int i = 0; i < n; i++) begin
            b.data = {$urandom, $urandom};
            b.keep = 8'($urandom);
            b.id   = 8'($urandom);
            b.dest = 8'($urandom);
            b.user = (i == 0) ? {16'($urandom), port, ip} : {$urandom, $urandom};
            b.last = (i == n - 1);
            e = b;
            if (route == 1) begin
                e.user = {16'h0000, port, ip};
                q_rtr.push_back(e);
            end else if (route == 2) begin
                e.user = {port, lan, loc};
                q_lp.push_back(e);
            end
            if (gaps && $urandom_range(0, 3) == 0) begin
                from_switch_tvalid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            if (mid_ip && i > 0 && $urandom_range(0, 2) == 0)
                i_local_ip_address = $urandom_range(0, 1) ? IP_A : IP_B;
            from_switch_tdata = b.data;
            from_switch_tkeep = b.keep;
            from_switch_tid   = b.id;
            from_switch_tdest = b.dest;
            from_switch_tuser = b.user;
            from_switch_tlast = b.last;
            send_beat(w);
            stalls += w;
            if (chk_lat && i == 0) begin
                check("latency_router_tvalid", 64'(to_router_tvalid), 64'(route == 1));
                check("latency_loop_tvalid", 64'(to_loopback_tvalid), 64'(route == 2));
            end
        end
        from_switch_tvalid = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        rand_ready = 1'b0;
        to_router_tready   = 1'b1;
        to_loopback_tready = 1'b1;
        cyc = 0;
        while ((q_rtr.size() != 0 || q_lp.size() != 0) && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_router_left", 64'(q_rtr.size()), 64'd0);
        check("drain_loop_left", 64'(q_lp.size()), 64'd0);
    endtask

    initial begin
        int st;
        int r;
        logic [31:0] ip;
        i_ap_rst           = 1'b1;
        i_local_ip_address = IP_A;
        i_LAN_port_number  = 16'h7000;
        from_switch_tvalid = 1'b0;
        from_switch_tdata  = '0;
        from_switch_tkeep  = '0;
        from_switch_tid    = '0;
        from_switch_tdest  = '0;
        from_switch_tuser  = '0;
        from_switch_tlast  = 1'b0;
        to_router_tready   = 1'b1;
        to_loopback_tready = 1'b1;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        i_ap_rst = 1'b0;
        check("rst_router_tvalid", 64'(to_router_tvalid), 64'd0);
        check("rst_loop_tvalid", 64'(to_loopback_tvalid), 64'd0);
        check("rst_drop_count", 64'(o_drop_count), 64'd0);
        check("rst_tready", 64'(from_switch_tready), 64'd1);
        check("rst_router_tdata", to_router_tdata, 64'd0);

        // Router-bound packet with latency check.
        send_packet(32'h0A000002, 16'h1234, 4, 1'b0, 1'b1, 1'b0, st);
        // Loopback packet.
        send_packet(IP_A, 16'h5555, 3, 1'b0, 1'b1, 1'b0, st);
        drain();

        // Two dropped packets: no stalls, no output, counter 2.
        send_packet(32'd0, 16'h0001, 3, 1'b0, 1'b0, 1'b0, st);
        check("drop1_stalls", 64'(st), 64'd0);
        send_packet(32'd0, 16'h0002, 1, 1'b0, 1'b0, 1'b0, st);
        check("drop2_stalls", 64'(st), 64'd0);
        @(posedge clk);
        #1;
        check("drop_count_2", 64'(o_drop_count), 64'(drop_exp));
        drain();

        // Randomized mixed traffic with backpressure and mid-packet local IP changes.
        rand_ready = 1'b1;
        for (int p = 0; p < 100; p++) begin
            r = $urandom_range(0, 9);
            if (r == 0) ip = 32'd0;
            else if (r < 4) ip = i_local_ip_address;
            else ip = $urandom | 32'd1;
            i_LAN_port_number = 16'($urandom);
            send_packet(ip, 16'($urandom), $urandom_range(1, 6), 1'b1, 1'b0, 1'b1, st);
        end
        drain();
        check("random_drop_count", 64'(o_drop_count), 64'(drop_exp));

        // Reset pulsed while beat 1 of a packet is stuck in the output stage.
        i_local_ip_address = IP_A;
        to_router_tready   = 1'b0;
        to_loopback_tready = 1'b0;
        from_switch_tdata  = 64'hDEAD_BEEF_0000_0001;
        from_switch_tuser  = {16'h0000, 16'h2222, 32'h0A000009};
        from_switch_tlast  = 1'b0;
        send_beat(st);
        from_switch_tdata  = 64'hDEAD_BEEF_0000_0002;
        from_switch_tuser  = {$urandom, $urandom};
        i_ap_rst = 1'b1;
        @(posedge clk);
        #1;
        i_ap_rst = 1'b0;
        from_switch_tvalid = 1'b0;
        drop_exp = 16'd0;
        check("midrst_router_tvalid", 64'(to_router_tvalid), 64'd0);
        check("midrst_loop_tvalid", 64'(to_loopback_tvalid), 64'd0);
        check("midrst_tready", 64'(from_switch_tready), 64'd1);
        check("midrst_drop_count", 64'(o_drop_count), 64'd0);
        to_router_tready   = 1'b1;
        to_loopback_tready = 1'b1;
        send_packet(IP_A, 16'h4242, 3, 1'b0, 1'b1, 1'b0, st);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
